multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/mips_ctrl_pkg.sv | 50 +++++
 rtl/mc_output_decode.sv | 105 ++++++++++
 rtl/multicycle_control.sv | 100 ++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: state codes, opcodes and mux/ALU selects.
package mips_ctrl_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned INSTR_W = 32;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    R_EXEC    = 4'd7,
    R_WB      = 4'd8,
    BRANCH    = 4'd9,
    JUMP      = 4'd10,
    ADDI_EX   = 4'd11,
    ADDI_WB   = 4'd12
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BROFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // True for opcodes the control unit knows how to sequence.
  function automatic logic is_known_op(input logic [OP_W-1:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational decode of the current control state (plus fetch-time inputs) into datapath strobes.
module mc_output_decode
  import mips_ctrl_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  input  logic [OP_W-1:0]    opcode,
  input  logic               interrupt,
  input  logic               memReady,
  output logic               pcWrite,
  output logic               pcWriteCond,
  output logic               iorD,
  output logic               memRead,
  output logic               memWrite,
  output logic               irWrite,
  output logic               memtoReg,
  output logic               regDst,
  output logic               regWrite,
  output logic               aluSrcA,
  output logic [1:0]         aluSrcB,
  output logic [1:0]         aluOp,
  output logic [1:0]         pcSource,
  output logic               illegal,
  output logic               halted
);

  always_comb begin
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    memtoReg    = 1'b0;
    regDst      = 1'b0;
    regWrite    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    aluOp       = 2'b00;
    pcSource    = 2'b00;
    illegal     = 1'b0;
    halted      = 1'b0;
    case (state)
      FETCH: begin
        // A pending interrupt parks the fetch with every strobe quiet.
        if (interrupt) begin
          halted = 1'b1;
        end else begin
          memRead  = 1'b1;
          aluSrcB  = SRCB_FOUR;
          aluOp    = ALUOP_ADD;
          pcSource = PCSRC_ALU;
          irWrite  = memReady;
          pcWrite  = memReady;
        end
      end
      DECODE: begin
        aluSrcB = SRCB_BROFF;
        aluOp   = ALUOP_ADD;
        illegal = !is_known_op(opcode);
      end
      MEM_ADDR, ADDI_EX: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
        aluOp   = ALUOP_ADD;
      end
      MEM_READ: begin
        memRead = 1'b1;
        iorD    = 1'b1;
      end
      MEM_WB: begin
        regWrite = 1'b1;
        memtoReg = 1'b1;
      end
      MEM_WRITE: begin
        memWrite = 1'b1;
        iorD     = 1'b1;
      end
      R_EXEC: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_REG;
        aluOp   = ALUOP_FUNCT;
      end
      R_WB: begin
        regWrite = 1'b1;
        regDst   = 1'b1;
      end
      BRANCH: begin
        aluSrcA     = 1'b1;
        aluSrcB     = SRCB_REG;
        aluOp       = ALUOP_SUB;
        pcWriteCond = 1'b1;
        pcSource    = PCSRC_ALUOUT;
      end
      JUMP: begin
        pcWrite  = 1'b1;
        pcSource = PCSRC_JUMP;
      end
      ADDI_WB: begin
        regWrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: state sequencing, retired-instruction counter and output decode.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [OP_W-1:0]    opcode,
  input  logic               zero,
  input  logic               memReady,
  input  logic               interrupt,
  output logic               pcWrite,
  output logic               pcWriteCond,
  output logic               iorD,
  output logic               memRead,
  output logic               memWrite,
  output logic               irWrite,
  output logic               memtoReg,
  output logic               regDst,
  output logic               regWrite,
  output logic               aluSrcA,
  output logic [1:0]         aluSrcB,
  output logic [1:0]         aluOp,
  output logic [1:0]         pcSource,
  output logic [STATE_W-1:0] state,
  output logic               illegal,
  output logic               halted,
  output logic [INSTR_W-1:0] instret
);

  state_t             state_q;
  logic [INSTR_W-1:0] instret_q;

  // The branch condition is combined with pcWriteCond by the datapath, not here.
  logic unused_zero;
  assign unused_zero = zero;

  // State sequencing; instret counts only completed instructions re-entering FETCH.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      instret_q <= '0;
    end else begin
      case (state_q)
        IDLE:     state_q <= FETCH;
        FETCH:    if (!interrupt && memReady) state_q <= DECODE;
        DECODE: begin
          case (opcode)
            OP_RTYPE:     state_q <= R_EXEC;
            OP_LW, OP_SW: state_q <= MEM_ADDR;
            OP_BEQ:       state_q <= BRANCH;
            OP_J:         state_q <= JUMP;
            OP_ADDI:      state_q <= ADDI_EX;
            default:      state_q <= FETCH;
          endcase
        end
        MEM_ADDR: state_q <= (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
        MEM_READ: if (memReady) state_q <= MEM_WB;
        MEM_WRITE: begin
          if (memReady) begin
            state_q   <= FETCH;
            instret_q <= instret_q + INSTR_W'(1);
          end
        end
        R_EXEC:   state_q <= R_WB;
        ADDI_EX:  state_q <= ADDI_WB;
        MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB: begin
          state_q   <= FETCH;
          instret_q <= instret_q + INSTR_W'(1);
        end
        default:  state_q <= FETCH;
      endcase
    end
  end

  assign state   = state_q;
  assign instret = instret_q;

  mc_output_decode u_decode (
    .state       (state_q),
    .opcode      (opcode),
    .interrupt   (interrupt),
    .memReady    (memReady),
    .pcWrite     (pcWrite),
    .pcWriteCond (pcWriteCond),
    .iorD        (iorD),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .irWrite     (irWrite),
    .memtoReg    (memtoReg),
    .regDst      (regDst),
    .regWrite    (regWrite),
    .aluSrcA     (aluSrcA),
    .aluSrcB     (aluSrcB),
    .aluOp       (aluOp),
    .pcSource    (pcSource),
    .illegal     (illegal),
    .halted      (halted)
  );

endmodule
